// File: rtl/i2c_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_ctrl
//  Purpose  : Write-only I2C slave front end. Receives a device address
//             byte, a register address byte and any number of data bytes,
//             ACKing each one, and emits one-cycle load enables so that
//             downstream address / data registers capture data_o.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    SCL         in   1  I2C serial clock (the only clock, posedge active)
//    rst_n       in   1  asynchronous active-low reset
//    sda_i       in   1  SDA line value, sampled on posedge SCL
//    start_det   in   1  START / repeated START seen since previous SCL rise
//    stop_det    in   1  STOP seen since previous SCL rise
//    data_o      out  8  last received byte (address or data)
//    load_addr0  out  1  register-address register captures data_o next edge
//    load_data   out  1  data register captures data_o next edge
//    sda_oe      out  1  1 = pull SDA low (ACK)
//    busy        out  1  1 while a transaction is addressed or in progress
//    wr_cnt      out  8  data bytes written in the current transaction
// ============================================================================
module i2c_slave_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       SCL,
    input  logic       rst_n,
    input  logic       sda_i,
    input  logic       start_det,
    input  logic       stop_det,
    output logic [7:0] data_o,
    output logic       load_addr0,
    output logic       load_data,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] wr_cnt
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEV_ADDR = 3'd1;
    localparam logic [2:0] ST_DEV_ACK  = 3'd2;
    localparam logic [2:0] ST_REG_ADDR = 3'd3;
    localparam logic [2:0] ST_REG_ACK  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_DATA_ACK = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [2:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       last_bit;

    // Byte as it stands once the current edge's bit is shifted in; only
    // meaningful when last_bit is set.
    assign rx_byte  = {shreg[6:0], sda_i};
    assign last_bit = (bit_cnt == 3'd7);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge SCL or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            data_o     <= 8'h00;
            wr_cnt     <= 8'h00;
            load_addr0 <= 1'b0;
            load_data  <= 1'b0;
            sda_oe     <= 1'b0;
        end else if (start_det) begin
            // The edge that reports START already carries address bit 7.
            state      <= ST_DEV_ADDR;
            shreg      <= rx_byte;
            bit_cnt    <= 3'd1;
            wr_cnt     <= 8'h00;
            load_addr0 <= 1'b0;
            load_data  <= 1'b0;
            sda_oe     <= 1'b0;
        end else if (stop_det) begin
            // wr_cnt deliberately holds so the count stays readable after STOP.
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            load_addr0 <= 1'b0;
            load_data  <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end

                ST_DEV_ADDR: begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        if ((rx_byte[7:1] == DEV_ADDR) && !rx_byte[0]) begin
                            sda_oe <= 1'b1;
                            state  <= ST_DEV_ACK;
                        end else begin
                            state  <= ST_IGNORE;
                        end
                    end
                end

                ST_DEV_ACK: begin
                    sda_oe  <= 1'b0;
                    bit_cnt <= 3'd0;
                    state   <= ST_REG_ADDR;
                end

                ST_REG_ADDR: begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        data_o     <= rx_byte;
                        load_addr0 <= 1'b1;
                        sda_oe     <= 1'b1;
                        state      <= ST_REG_ACK;
                    end
                end

                ST_REG_ACK: begin
                    load_addr0 <= 1'b0;
                    sda_oe     <= 1'b0;
                    bit_cnt    <= 3'd0;
                    state      <= ST_DATA;
                end

                ST_DATA: begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        data_o    <= rx_byte;
                        load_data <= 1'b1;
                        sda_oe    <= 1'b1;
                        state     <= ST_DATA_ACK;
                    end
                end

                ST_DATA_ACK: begin
                    load_data <= 1'b0;
                    sda_oe    <= 1'b0;
                    bit_cnt   <= 3'd0;
                    if (wr_cnt != 8'hFF) begin
                        wr_cnt <= wr_cnt + 8'h01;
                    end
                    state     <= ST_DATA;
                end

                ST_IGNORE: begin
                    state <= ST_IGNORE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit slave device address the block acknowledges.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- SCL  input  1  I2C serial clock; the only clock; all state updates on posedge SCL.
- rst_n  input  1  asynchronous active-low reset.
- sda_i  input  1  SDA line value, sampled on posedge SCL.
- start_det  input  1  START or repeated START seen since the previous SCL rise; driven by an external detector, held until that next posedge.
- stop_det  input  1  STOP seen since the previous SCL rise; same timing as start_det.
- data_o  output  8  last received byte; feeds data_i of the address and data registers.
- load_addr0  output  1  enable: the register-address register captures data_o on the next posedge SCL.
- load_data  output  1  enable: the data register captures data_o on the next posedge SCL.
- sda_oe  output  1  1 = pull SDA low (ACK).
- busy  output  1  1 while a transaction is addressed or in progress.
- wr_cnt  output  8  count of data bytes written in the current transaction.

Function
REQ-003 The FSM states SHALL be IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK and IGNORE.
REQ-004 Shifting: in DEV_ADDR, REG_ADDR and DATA, each posedge SHALL do shreg <= {shreg[6:0], sda_i} and bit_cnt <= bit_cnt+1 (3 bits); byte = {shreg[6:0], sda_i} when bit_cnt==7.
REQ-005 start_det=1 at a posedge, from any state, SHALL:
- enter DEV_ADDR;
- treat that edge's sda_i as address bit 7, so bit_cnt <= 1;
- clear wr_cnt, sda_oe, load_addr0 and load_data.
REQ-006 stop_det=1 at a posedge (start_det=0) SHALL enter IDLE, capture no bit, and clear sda_oe, load_addr0 and load_data; wr_cnt SHALL hold its value.
REQ-007 If start_det and stop_det are both 1, start_det SHALL win.
REQ-008 DEV_ADDR at bit_cnt==7:
- byte[7:1]==DEV_ADDR and byte[0]==0 (write) -> sda_oe <= 1, enter DEV_ACK;
- otherwise (address mismatch or read) -> sda_oe stays 0, enter IGNORE.
REQ-009 DEV_ACK SHALL, on the next posedge, set sda_oe <= 0 and bit_cnt <= 0, then enter REG_ADDR.
REQ-010 REG_ADDR at bit_cnt==7 SHALL set data_o <= byte, load_addr0 <= 1 and sda_oe <= 1, then enter REG_ACK.
REQ-011 REG_ACK SHALL, on the next posedge (the posedge where the downstream register captures), clear load_addr0 and sda_oe, then enter DATA.
REQ-012 DATA at bit_cnt==7 SHALL set data_o <= byte, load_data <= 1 and sda_oe <= 1, then enter DATA_ACK.
REQ-013 DATA_ACK SHALL, on the next posedge, clear load_data and sda_oe, increment wr_cnt (saturating at 8'hFF), then return to DATA.
REQ-014 load_addr0 and load_data SHALL each be exactly one SCL cycle wide and SHALL never be asserted together.
REQ-015 IGNORE SHALL hold all outputs and leave only on start_det or stop_det.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 In IDLE, all posedges without start_det SHALL be ignored.
REQ-018 data_o SHALL hold its value between loads.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, shreg=0, bit_cnt=0, data_o=8'h00, wr_cnt=8'h00, and load_addr0, load_data, sda_oe and busy to 0.
REQ-020 Reset asserted mid-byte or mid-ACK SHALL release SDA immediately, with no load pulse afterwards.
REQ-021 After rst_n rises, the block SHALL wait for start_det before responding.

Verification
REQ-022 The bench SHALL cover: START + 8'hA0, 8'h12, 8'h34, STOP -> ACK on all three 9th clocks; load_addr0 one cycle with data_o=8'h12; load_data one cycle with data_o=8'h34; final wr_cnt=1; busy=0 after STOP.
REQ-023 The bench SHALL cover: START + 8'hA2 (address mismatch) -> sda_oe stays 0, state IGNORE, no load pulses until the next start_det.
REQ-024 The bench SHALL cover: START + 8'hA1 (read request) -> NACK, IGNORE.
REQ-025 The bench SHALL cover: START + 8'hA0, 8'h05, 8'h11, then repeated START (start_det with stop_det also high) + 8'hA0 -> DEV_ADDR re-entered, wr_cnt cleared, second address ACKed.
REQ-026 The bench SHALL cover: 260 data bytes in one transaction -> wr_cnt saturates at 8'hFF.
REQ-027 The bench SHALL cover: rst_n pulsed while sda_oe=1 in REG_ACK -> sda_oe, load_addr0 and busy drop at once, with no capture afterwards.
